// File: rtl/rst_seq_ctrl_if.sv
// Handshake bundle between the reset sequencer (master) and the reset domains it controls.
// N_STAGES must match the controller instance it is bound to.
interface rst_seq_ctrl_if #(
  parameter int N_STAGES = 4
);
  logic                sw_rst_req;
  logic [N_STAGES-1:0] stage_ack;
  logic [N_STAGES-1:0] stage_rst;
  logic                busy;
  logic                done;
  logic                err;
  logic [2:0]          err_stage;

  modport master (
    input  sw_rst_req,
    input  stage_ack,
    output stage_rst,
    output busy,
    output done,
    output err,
    output err_stage
  );

  modport slave (
    output sw_rst_req,
    output stage_ack,
    input  stage_rst,
    input  busy,
    input  done,
    input  err,
    input  err_stage
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds every domain in reset, then releases them one at a time in order,
// waiting for each domain's ack with a per-stage timeout. All outputs are registered.
module rst_seq_ctrl #(
  parameter int N_STAGES    = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int TIMEOUT     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  rst_seq_ctrl_if.master   bus
);

  localparam int CNT_MAX = (HOLD_CYCLES > TIMEOUT) ? HOLD_CYCLES : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]       IDX_LAST  = 3'(N_STAGES - 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2,
    ST_ERROR   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          idx_q, idx_d;
  logic [2:0]          err_stage_q, err_stage_d;
  logic [N_STAGES-1:0] stage_rst_q, stage_rst_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [7:0]          ack_ext;
  logic [N_STAGES-1:0] rel_mask;

  // Pad acks to the full 3-bit index range so idx can select without width games.
  for (genvar gi = 0; gi < 8; gi++) begin : g_ack
    if (gi < N_STAGES) begin : g_used
      assign ack_ext[gi] = bus.stage_ack[gi];
    end else begin : g_pad
      assign ack_ext[gi] = 1'b0;
    end
  end

  // Stages above the next index stay in reset; those at or below it are released.
  for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_mask
    assign rel_mask[gi] = (3'(gi) > idx_d);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    err_stage_d = err_stage_q;

    unique case (state_q)
      ST_ASSERT: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_RELEASE;
          idx_d   = 3'd0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_RELEASE: begin
        if (bus.sw_rst_req) begin
          state_d     = ST_ASSERT;
          cnt_d       = '0;
          idx_d       = 3'd0;
          err_stage_d = 3'd0;
        end else if (ack_ext[idx_q]) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d     = ST_ERROR;
          err_stage_d = idx_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_DONE, ST_ERROR: begin
        if (bus.sw_rst_req) begin
          state_d     = ST_ASSERT;
          cnt_d       = '0;
          idx_d       = 3'd0;
          err_stage_d = 3'd0;
        end
      end

      default: begin
        state_d = ST_ASSERT;
        cnt_d   = '0;
        idx_d   = 3'd0;
      end
    endcase
  end

  // Outputs are derived from the next state so they appear on the same edge as the transition.
  always_comb begin
    stage_rst_d = '1;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;

    unique case (state_d)
      ST_ASSERT: begin
        stage_rst_d = '1;
        busy_d      = 1'b1;
      end
      ST_RELEASE: begin
        stage_rst_d = rel_mask;
        busy_d      = 1'b1;
      end
      ST_DONE: begin
        stage_rst_d = '0;
        done_d      = 1'b1;
      end
      ST_ERROR: begin
        stage_rst_d = '1;
        err_d       = 1'b1;
      end
      default: begin
        stage_rst_d = '1;
        busy_d      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_ASSERT;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      err_stage_q <= 3'd0;
      stage_rst_q <= '1;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      err_stage_q <= err_stage_d;
      stage_rst_q <= stage_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.stage_rst = stage_rst_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.err_stage = err_stage_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: a 4-stage instance with default timing and a 1-stage
// instance with short hold/timeout; expected outputs go through a scoreboard queue.
module tb_rst_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst1_n;

  rst_seq_ctrl_if #(.N_STAGES(4)) bus  ();
  rst_seq_ctrl_if #(.N_STAGES(1)) bus1 ();

  rst_seq_ctrl #(.N_STAGES(4), .HOLD_CYCLES(8), .TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  rst_seq_ctrl #(.N_STAGES(1), .HOLD_CYCLES(2), .TIMEOUT(3)) dut1 (
    .clk   (clk),
    .rst_n (rst1_n),
    .bus   (bus1)
  );

  typedef struct {
    bit         sel;
    logic [7:0] rst;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] es;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check_front();
    exp_t        e;
    logic [13:0] obs;
    logic [13:0] want;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed 0 entries, expected 1");
      return;
    end
    e = exp_q.pop_front();
    if (e.sel)
      obs = {7'b0, bus1.stage_rst, bus1.busy, bus1.done, bus1.err, bus1.err_stage};
    else
      obs = {4'b0, bus.stage_rst, bus.busy, bus.done, bus.err, bus.err_stage};
    want = {e.rst, e.busy, e.done, e.err, e.es};
    $display("[%0t] dut%0d %s rst=%h busy=%b done=%b err=%b es=%0d",
             $time, e.sel, e.tag, obs[13:6], obs[5], obs[4], obs[3], obs[2:0]);
    assert (obs === want)
    else begin
      miscompares++;
      $error("FAIL %s: observed rst=%h busy=%b done=%b err=%b es=%0d, expected rst=%h busy=%b done=%b err=%b es=%0d",
             e.tag, obs[13:6], obs[5], obs[4], obs[3], obs[2:0],
             want[13:6], want[5], want[4], want[3], want[2:0]);
    end
  endtask

  // Drive one cycle of inputs, record the expected post-edge outputs, then compare after the edge.
  task automatic step(input bit sel, input logic r, input logic s, input logic [3:0] a,
                      input logic [7:0] e_rst, input logic e_busy, input logic e_done,
                      input logic e_err, input logic [2:0] e_es, input string tag);
    exp_t e;
    if (sel) begin
      rst1_n          = r;
      bus1.sw_rst_req = s;
      bus1.stage_ack  = a[0];
    end else begin
      rst_n          = r;
      bus.sw_rst_req = s;
      bus.stage_ack  = a;
    end
    e.sel  = sel;
    e.rst  = e_rst;
    e.busy = e_busy;
    e.done = e_done;
    e.err  = e_err;
    e.es   = e_es;
    e.tag  = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_front();
  endtask

  task automatic hold7(input logic [3:0] a, input string tag);
    for (int i = 1; i <= 7; i++) step(0, 1, 0, a, 8'hF, 1, 0, 0, 0, tag);
  endtask

  initial begin
    rst_n           = 1'b0;
    rst1_n          = 1'b0;
    bus.sw_rst_req  = 1'b0;
    bus.stage_ack   = 4'h0;
    bus1.sw_rst_req = 1'b0;
    bus1.stage_ack  = 1'b0;

    // Reset state and nominal sequence with all acks high
    step(0, 0, 0, 4'hF, 8'hF, 1, 0, 0, 0, "reset_a");
    step(0, 0, 0, 4'hF, 8'hF, 1, 0, 0, 0, "reset_b");
    hold7(4'hF, "hold_e1_e7");
    step(0, 1, 0, 4'hF, 8'hE, 1, 0, 0, 0, "release_s0");
    step(0, 1, 0, 4'hF, 8'hC, 1, 0, 0, 0, "release_s1");
    step(0, 1, 0, 4'hF, 8'h8, 1, 0, 0, 0, "release_s2");
    step(0, 1, 0, 4'hF, 8'h0, 1, 0, 0, 0, "release_s3");
    step(0, 1, 0, 4'hF, 8'h0, 0, 1, 0, 0, "done");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 4'h0, 8'h0, 0, 1, 0, 0, "done_hold");

    // Software re-run from DONE; a request during ASSERT must not restart the hold
    step(0, 1, 1, 4'h1, 8'hF, 1, 0, 0, 0, "sw_from_done");
    for (int i = 1; i <= 7; i++) step(0, 1, (i == 3), 4'h1, 8'hF, 1, 0, 0, 0, "hold_sw_ignored");
    step(0, 1, 0, 4'h1, 8'hE, 1, 0, 0, 0, "release_s0_b");
    step(0, 1, 0, 4'h1, 8'hC, 1, 0, 0, 0, "release_s1_b");
    for (int i = 0; i < 15; i++) step(0, 1, 0, 4'h1, 8'hC, 1, 0, 0, 0, "wait_ack1");
    step(0, 1, 0, 4'h1, 8'hF, 0, 0, 1, 1, "timeout_s1");
    for (int i = 0; i < 2; i++) step(0, 1, 0, 4'hF, 8'hF, 0, 0, 1, 1, "err_hold");

    // Recovery from ERROR; later stages acking early must not be released out of order
    step(0, 1, 1, 4'hE, 8'hF, 1, 0, 0, 0, "sw_from_err");
    hold7(4'hE, "hold_after_err");
    step(0, 1, 0, 4'hE, 8'hE, 1, 0, 0, 0, "release_s0_c");
    for (int i = 0; i < 5; i++) step(0, 1, 0, 4'hE, 8'hE, 1, 0, 0, 0, "early_acks_ignored");
    step(0, 1, 0, 4'hF, 8'hC, 1, 0, 0, 0, "ack0_rises");
    step(0, 1, 0, 4'hF, 8'h8, 1, 0, 0, 0, "release_s2_c");

    // Hard reset mid-release restarts the full hold from stage 0
    step(0, 0, 0, 4'hF, 8'hF, 1, 0, 0, 0, "rst_mid_release");
    hold7(4'hF, "hold_after_rst");
    step(0, 1, 0, 4'hF, 8'hE, 1, 0, 0, 0, "release_s0_d");

    // Software request beats a same-edge ack
    step(0, 1, 1, 4'hF, 8'hF, 1, 0, 0, 0, "sw_beats_ack");
    hold7(4'hF, "hold_after_sw");
    step(0, 1, 0, 4'hF, 8'hE, 1, 0, 0, 0, "release_s0_e");
    for (int i = 0; i < 15; i++) step(0, 1, 0, 4'h0, 8'hE, 1, 0, 0, 0, "wait_ack0");
    step(0, 1, 0, 4'h0, 8'hF, 0, 0, 1, 0, "timeout_s0");
    step(0, 0, 0, 4'h0, 8'hF, 1, 0, 0, 0, "rst_in_err");

    // Single-stage instance: HOLD_CYCLES=2, TIMEOUT=3
    step(1, 0, 0, 4'h0, 8'h1, 1, 0, 0, 0, "n1_reset");
    step(1, 1, 0, 4'h1, 8'h1, 1, 0, 0, 0, "n1_hold");
    step(1, 1, 0, 4'h1, 8'h0, 1, 0, 0, 0, "n1_release");
    step(1, 1, 0, 4'h1, 8'h0, 0, 1, 0, 0, "n1_done");
    step(1, 1, 1, 4'h0, 8'h1, 1, 0, 0, 0, "n1_sw");
    step(1, 1, 0, 4'h0, 8'h1, 1, 0, 0, 0, "n1_hold_b");
    step(1, 1, 0, 4'h0, 8'h0, 1, 0, 0, 0, "n1_release_b");
    step(1, 1, 0, 4'h0, 8'h0, 1, 0, 0, 0, "n1_wait_a");
    step(1, 1, 0, 4'h0, 8'h0, 1, 0, 0, 0, "n1_wait_b");
    step(1, 1, 0, 4'h0, 8'h1, 0, 0, 1, 0, "n1_timeout");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
